// File: rtl/perf_pkg.sv
// Shared types and helpers for the commit performance-counter bank.
package perf_pkg;

  localparam int unsigned PERF_NUM = 14;

  // Counter index map; also the read address of each counter.
  typedef enum logic [3:0] {
    PerfCycle   = 4'd0,
    PerfInst    = 4'd1,
    PerfJal     = 4'd2,
    PerfJalr    = 4'd3,
    PerfBr      = 4'd4,
    PerfLoad    = 4'd5,
    PerfStore   = 4'd6,
    PerfOther   = 4'd7,
    PerfFlush   = 4'd8,
    PerfIcHit   = 4'd9,
    PerfIcMiss  = 4'd10,
    PerfDcHit   = 4'd11,
    PerfDcMiss  = 4'd12,
    PerfRvsWait = 4'd13
  } perf_idx_e;

  typedef enum logic [1:0] {
    StRun,
    StFrz,
    StSnap
  } perf_state_e;

  // RV32I major opcodes, instruction bits [6:0].
  typedef enum logic [6:0] {
    OpLui   = 7'b0110111,
    OpAuipc = 7'b0010111,
    OpJal   = 7'b1101111,
    OpJalr  = 7'b1100111,
    OpBr    = 7'b1100011,
    OpLoad  = 7'b0000011,
    OpStore = 7'b0100011,
    OpImm   = 7'b0010011,
    OpReg   = 7'b0110011,
    OpCsr   = 7'b1110011
  } rv32i_opcode_e;

  typedef enum logic [2:0] {
    ClsJal,
    ClsJalr,
    ClsBr,
    ClsLoad,
    ClsStore,
    ClsOther
  } op_class_e;

  // Map a committed opcode onto the counter class it feeds.
  function automatic op_class_e decode_op_class(logic [6:0] opcode);
    op_class_e cls;
    case (opcode)
      OpJal:   cls = ClsJal;
      OpJalr:  cls = ClsJalr;
      OpBr:    cls = ClsBr;
      OpLoad:  cls = ClsLoad;
      OpStore: cls = ClsStore;
      default: cls = ClsOther;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/commit_perf_counters_sat_counter.sv
// Single saturating event counter with clear and hold.
module perf_sat_counter #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            hold_i,
  input  logic            inc_i,
  output logic [CntW-1:0] count_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !hold_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/commit_perf_counters.sv
// Performance-counter bank fed by the ROB commit monitor and cache / RS strobes.
// Live counters are copied into a shadow bank on request; reads serve the shadow.
module commit_perf_counters
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NUM_CNT = PERF_NUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_valid_i,
  input  logic [31:0]      mon_inst_i,
  input  logic             flush_i,
  input  logic             ic_hit_i,
  input  logic             ic_miss_i,
  input  logic             dc_hit_i,
  input  logic             dc_miss_i,
  input  logic             rvs_req_i,
  input  logic             rvs_rdy_i,
  input  logic             freeze_i,
  input  logic             clr_i,
  input  logic             snap_req_i,
  output logic             snap_done_o,
  input  logic             rd_req_i,
  input  logic [3:0]       rd_addr_i,
  output logic             rd_rdy_o,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] rd_data_o
);

  perf_state_e state_q, state_d;
  op_class_e   cls;

  logic [PERF_NUM-1:0] ev;
  logic                hold;
  logic                snap_copy;
  logic                rd_accept;

  logic [CNT_W-1:0] live     [16];
  logic [CNT_W-1:0] shadow_q [16];

  logic             snap_done_q, snap_done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  logic unused_inst_hi;
  assign unused_inst_hi = ^mon_inst_i[31:7];

  // Per-cycle event strobes, one bit per counter.
  always_comb begin
    cls                = decode_op_class(mon_inst_i[6:0]);
    ev                 = '0;
    ev[PerfCycle]      = 1'b1;
    ev[PerfInst]       = mon_valid_i;
    ev[PerfJal]        = mon_valid_i && (cls == ClsJal);
    ev[PerfJalr]       = mon_valid_i && (cls == ClsJalr);
    ev[PerfBr]         = mon_valid_i && (cls == ClsBr);
    ev[PerfLoad]       = mon_valid_i && (cls == ClsLoad);
    ev[PerfStore]      = mon_valid_i && (cls == ClsStore);
    ev[PerfOther]      = mon_valid_i && (cls == ClsOther);
    ev[PerfFlush]      = flush_i;
    ev[PerfIcHit]      = ic_hit_i;
    ev[PerfIcMiss]     = ic_miss_i;
    ev[PerfDcHit]      = dc_hit_i;
    ev[PerfDcMiss]     = dc_miss_i;
    ev[PerfRvsWait]    = rvs_req_i && !rvs_rdy_i;
  end

  // Live counters; unimplemented addresses are tied to zero.
  for (genvar i = 0; i < 16; i++) begin : g_cnt
    if ((i < NUM_CNT) && (i < PERF_NUM)) begin : g_impl
      perf_sat_counter #(
        .CntW(CNT_W)
      ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_i),
        .hold_i (hold),
        .inc_i  (ev[i]),
        .count_o(live[i])
      );
    end else begin : g_zero
      assign live[i] = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a snapshot request beats freeze, and is ignored mid-snapshot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (snap_req_i) state_d = StSnap;
               else if (freeze_i) state_d = StFrz;
      StFrz:   if (snap_req_i) state_d = StSnap;
               else if (!freeze_i) state_d = StRun;
      StSnap:  state_d = freeze_i ? StFrz : StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM outputs: counter hold, shadow copy strobe, read-port ready.
  always_comb begin
    hold      = (state_q == StFrz) || ((state_q == StSnap) && freeze_i);
    snap_copy = (state_q == StSnap);
    rd_rdy_o  = (state_q != StSnap);
    rd_accept = rd_req_i && rd_rdy_o;
  end

  // Next state of the completion pulse and read port; data holds when idle.
  always_comb begin
    snap_done_d = snap_copy;
    rd_valid_d  = rd_accept;
    rd_data_d   = rd_accept ? shadow_q[rd_addr_i] : rd_data_q;
  end

  // Shadow bank and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q    <= '{default: '0};
      snap_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (snap_copy) begin
        shadow_q <= live;
      end
      snap_done_q <= snap_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign snap_done_o = snap_done_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: doc/commit_perf_counters.md
Name: commit_perf_counters

Overview:
Synthesizable performance-counter bank that consumes the ROB commit monitor stream (valid, instruction, flush) plus cache and reservation-station event strobes. It accumulates per-class cycle and event counts in live counters. A snapshot handshake copies the live counters into a shadow bank, and a one-cycle-latency read port serves the shadow bank. Sits downstream of the ROB commit port and the I/D caches; it is the hardware counterpart of the simulation-only performance monitors.

Parameters:
CNT_W, 32, width of every counter; counters saturate at all-ones.
NUM_CNT, 14, number of implemented counters (indices 0..13).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
mon_valid  in  1  instruction committed this cycle (max one per cycle)
mon_inst  in  32  committed instruction word; opcode = mon_inst[6:0]
flush  in  1  pipeline flush strobe from ROB
ic_hit / ic_miss  in  1 each  I-cache CMP_TAG outcome strobes
dc_hit / dc_miss  in  1 each  D-cache CMP_TAG outcome strobes
rvs_req / rvs_rdy  in  1 each  decode-to-reservation-station handshake
freeze  in  1  level; when high, live counters hold
clr  in  1  pulse; zero all live counters
snap_req  in  1  pulse; request copy of live counters into shadow bank
snap_done  out  1  one-cycle pulse when the shadow bank has been updated
rd_req  in  1  read request
rd_addr  in  4  counter index
rd_rdy  out  1  read request may be accepted this cycle
rd_valid  out  1  read data valid
rd_data  out  CNT_W  read data

Behaviour:
- Reset (rst==0 at posedge): live and shadow counters = 0; snap_done = 0, rd_valid = 0, rd_data = 0; FSM enters S_RUN.
- Counter map:
  - 0 CYCLE: +1 every cycle.
  - 1 INST: mon_valid.
  - 2 JAL, 3 JALR, 4 BR, 5 LOAD, 6 STORE: mon_valid and the opcode matches that class.
  - 7 OTHER: mon_valid with any other opcode.
  - 8 FLUSH: flush.
  - 9 IC_HIT, 10 IC_MISS, 11 DC_HIT, 12 DC_MISS: the corresponding strobe.
  - 13 RVS_WAIT: rvs_req & ~rvs_rdy.
  - Addresses 14 and 15 read 0.
- Increments are registered; a counter reflects an event in the cycle after it.
- Each counter adds at most 1 per cycle. Saturation: all-ones + 1 = all-ones.
- FSM states:
  - S_RUN: counters increment. freeze=1 -> S_FRZ. snap_req=1 -> S_SNAP.
  - S_FRZ: live counters hold, including CYCLE. freeze=0 -> S_RUN. snap_req=1 -> S_SNAP.
  - S_SNAP (one cycle): shadow <= live value as of entry to this cycle. snap_done=1 in the following cycle. Live counters keep counting unless freeze is high. Returns to S_RUN or S_FRZ according to freeze.
- snap_req while in S_SNAP is ignored (no queuing).
- rd_rdy = 0 in S_SNAP; 1 otherwise.
- Read accept = rd_req & rd_rdy. rd_valid = 1 and rd_data = shadow[rd_addr] in the next cycle. Back-to-back reads are allowed, one per cycle.
- When no read is accepted, rd_valid = 0 and rd_data holds its previous value.
- clr priority: clr overrides same-cycle increments (live = 0 next cycle). clr does not affect the shadow bank.
- clr in the same cycle as the S_SNAP copy: shadow captures the pre-clear values.
- freeze does not block clr or snapshots.
- Reset mid-snapshot or mid-read: all state returns to reset values; no snap_done or rd_valid pulse is emitted.

Decomposition:
- Package perf_pkg:
  - enum perf_idx_e (CYCLE..RVS_WAIT), PERF_NUM = 14.
  - FSM state enum {S_RUN, S_FRZ, S_SNAP}.
  - Opcode class decode function built on rv32i_types::rv32i_opcode.
- One natural sub-module: perf_sat_counter (CNT_W-bit saturating counter with inc, clr, hold inputs), instantiated NUM_CNT times.

Test Plan:
- Reset, then 10 idle cycles, snap_req, read addr 0 -> snap_done one cycle after S_SNAP; rd_data = 11 (counted through the S_SNAP entry cycle); every other address reads 0.
- Commit 3 jal, 2 br, 4 load, 1 add (op_b_reg), then snapshot -> addr 1 = 10, 2 = 3, 4 = 2, 5 = 4, 7 = 1, 3 = 0, 6 = 0.
- freeze for 20 cycles with 5 mon_valid pulses, then snapshot -> INST and CYCLE unchanged versus the pre-freeze snapshot.
- Force live CNT_W=4 counter to 4'hF (parameter override), keep mon_valid high, snapshot -> INST reads 15, no wrap.
- clr asserted in the same cycle as a jal commit, then snapshot -> JAL = 0; a prior snapshot value read before the new snap_req still shows the old count.
- rd_req held high across snap_req -> rd_rdy = 0 in the S_SNAP cycle; no read accepted that cycle; reads resume the next cycle with post-snapshot data; rvs_req=1 & rvs_rdy=0 for 7 cycles -> addr 13 reads 7.
